dbus_uart: RTL and testbench
============================

// Module: dbus_uart
// PURPOSE
//  Memory-mapped UART slave on the CPU data bus (DBUS), downstream of the CPU's DBUS master port.
//  Consumes word-addressed DBUS read/write strobes from the interconnect.
//  Serialises TX bytes from an internal FIFO and deserialises RX into a single holding register.
//  8N1 framing, programmable baud divider, registered read data with one-cycle latency.
// PARAMETERS
//  TX_DEPTH          8    TX FIFO entries; power of two, >=2
//  DEFAULT_BAUD_DIV  867  clocks per bit minus 1 after reset (100 MHz / 115200)
// PORTS
//  i_Clk        in   1   clock; all logic rising-edge
//  i_Rst        in   1   asynchronous, active-high reset
//  i_Sel        in   1   interconnect address decode hit for this slave
//  i_DBusAddr   in   2   word offset within slave (low bits of 30-bit word address)
//  i_DBusRe     in   1   read strobe, single cycle
//  i_DBusWe     in   1   write strobe, single cycle
//  i_DBusByteEn in   4   byte-lane enables for writes
//  i_DBusWd     in   32  write data
//  o_DBusRd     out  32  read data, valid the cycle after i_DBusRe
//  i_UartRx     in   1   serial input, asynchronous to i_Clk
//  o_UartTx     out  1   serial output, idle high
//  o_Irq        out  1   level: RxValid | (TxEmpty & TxIrqEn)
// BEHAVIOUR
//  Reset: o_DBusRd=0, o_UartTx=1, o_Irq=0, FIFO empty, RxValid=0, flags=0, baud div=DEFAULT_BAUD_DIV, TxIrqEn=0.
//  Access only when i_Sel=1; Re and We never asserted together (a Re&We cycle is treated as a write only).
//  Registers (word offset):
//   0 DATA   W: lane0 enabled -> push WD[7:0]; R: {24'b0,RxByte}, clears RxValid
//   1 STATUS R: [0]TxFull [1]TxEmpty [2]RxValid [3]RxOverrun [4]FrameErr; read clears [4:3]; W ignored
//   2 BAUD   RW: [15:0] div; lanes 0/1 honoured separately; stored value clamped to >=4
//   3 CTRL   RW: [0] TxIrqEn
//  Read data: registered on Re, presented next cycle, 0 in every cycle not following a Re.
//  Read side effects occur on the Re cycle.
//  TX FIFO:
//   - push when full: dropped silently, no flag, pointers unchanged
//   - push+pop same cycle when full: both occur
//   - push+pop same cycle when empty: push only; pop next cycle
//  TX FSM, counter reloads div each bit:
//   IDLE  --FIFO not empty--> START (pop; tx=0, one bit time)
//   START --> DATA (8 bits LSB first, bit counter 0..7)
//   DATA  --after bit 7--> STOP (tx=1, one bit time)
//   STOP  --> IDLE, or directly to START if FIFO non-empty (back-to-back frames, no gap)
//  RX:
//   - 2-flop synchroniser.
//   - IDLE: wait for low; START: sample at div/2; if high -> false start -> IDLE.
//   - DATA: sample each full bit time. STOP: sample; low -> FrameErr set, byte still delivered.
//   - Back to IDLE.
//  Delivery boundaries:
//   - byte delivered while RxValid=1 -> overwrite RxByte, set RxOverrun
//   - delivery in same cycle as DATA read -> new byte kept, RxValid stays 1, no overrun
//   - flag set and STATUS read in same cycle -> flag stays set
//  BAUD write mid-frame: new div used from the next counter reload; current bit completes with old count.
//  Reset mid-frame: o_UartTx forced to 1 immediately; partial TX/RX frames discarded.
// STRUCTURE
//  Shared header dbus_uart_defs.vh:
//   - register offsets, STATUS bit indices, TX/RX FSM state encodings, baud-clamp minimum (4).
//  One sub-module: uart_fifo.
//   - synchronous FIFO; WIDTH, DEPTH parameters; push/pop/full/empty ports; async reset.
//  TX FSM, RX FSM and register file stay inline.
// TESTING
//  1 Reset then read STATUS -> next cycle o_DBusRd=32'h2, o_UartTx=1; read BAUD -> 867.
//  2 BAUD=15, write DATA 8'hA5 -> line shows start, 1,0,1,0,0,1,0,1, stop.
//    Each bit exactly 16 clocks; TxEmpty=1 after pop.
//  3 Write 9 bytes back-to-back with TX_DEPTH=8 while idle -> first pops, remaining 8 fill FIFO, TxFull=1.
//    9th byte transmitted, no 10th; frames contiguous.
//  4 Drive RX 8'h3C at BAUD=15 -> RxValid=1, o_Irq=1.
//    Read DATA -> 32'h3C next cycle, RxValid=0.
//  5 Two RX bytes without read -> RxOverrun=1, DATA=second byte.
//    STATUS read clears bit3; next read shows 0.
//  6 RX frame with stop bit low -> FrameErr=1, byte delivered.
//    10-clock low glitch at BAUD=31 -> no byte, RxValid stays 0.

Source files
------------

// File: rtl/dbus_uart_pkg.sv
// Shared definitions for the DBUS UART: register map, STATUS bit positions, FSM states, baud floor.
// No logic here beyond a divider clamp helper.
package dbus_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;

  localparam logic [15:0] BAUD_MIN = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < BAUD_MIN) ? BAUD_MIN : d;
  endfunction

endpackage

// File: rtl/dbus_uart_fifo.sv
// Synchronous FIFO with combinational head read; pop on empty is ignored.
// Push on full is dropped unless a pop frees a slot in the same cycle.
module dbus_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop    = pop_i & ~empty_o;
  assign do_push   = push_i & (~full_o | do_pop);
  assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/dbus_uart.sv
// DBUS-mapped 8N1 UART: TX bytes queue in a FIFO, RX lands in one holding register.
// Read data is registered (one-cycle latency); writes to a full TX FIFO are silently dropped.
module dbus_uart
  import dbus_uart_pkg::*;
#(
  parameter int          TX_DEPTH         = 8,
  parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd867
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Sel,
  input  logic [1:0]  i_DBusAddr,
  input  logic        i_DBusRe,
  input  logic        i_DBusWe,
  input  logic [3:0]  i_DBusByteEn,
  input  logic [31:0] i_DBusWd,
  output logic [31:0] o_DBusRd,
  input  logic        i_UartRx,
  output logic        o_UartTx,
  output logic        o_Irq
);
  logic        wr_hit, rd_hit, data_rd, status_rd;
  logic [31:0] rd_d, rd_q;
  logic [15:0] div_q, baud_wr;
  logic        irq_en_q;
  logic [7:0]  rx_byte_q;
  logic        rx_vld_q, overrun_q, frame_err_q;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dat;
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        rx_meta_q, rx_sync_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_deliver, rx_stop_low;
  logic        unused_w;

  // A cycle with both strobes is a write only.
  assign wr_hit    = i_Sel & i_DBusWe;
  assign rd_hit    = i_Sel & i_DBusRe & ~i_DBusWe;
  assign data_rd   = rd_hit & (i_DBusAddr == REG_DATA);
  assign status_rd = rd_hit & (i_DBusAddr == REG_STATUS);
  assign fifo_push = wr_hit & (i_DBusAddr == REG_DATA) & i_DBusByteEn[0];
  assign baud_wr   = {i_DBusByteEn[1] ? i_DBusWd[15:8] : div_q[15:8],
                      i_DBusByteEn[0] ? i_DBusWd[7:0]  : div_q[7:0]};
  assign unused_w  = ^{i_DBusWd[31:16], i_DBusByteEn[3:2]};

  dbus_uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i(i_Clk), .rst_i(i_Rst), .push_i(fifo_push), .push_dat_i(i_DBusWd[7:0]),
    .pop_i(fifo_pop), .pop_dat_o(fifo_dat), .full_o(fifo_full), .empty_o(fifo_empty)
  );

  always_comb begin
    rd_d = '0;
    if (rd_hit) begin
      case (i_DBusAddr)
        REG_DATA: rd_d = {24'b0, rx_byte_q};
        REG_STATUS: begin
          rd_d[ST_TX_FULL]    = fifo_full;
          rd_d[ST_TX_EMPTY]   = fifo_empty;
          rd_d[ST_RX_VALID]   = rx_vld_q;
          rd_d[ST_RX_OVERRUN] = overrun_q;
          rd_d[ST_FRAME_ERR]  = frame_err_q;
        end
        REG_BAUD: rd_d = {16'b0, div_q};
        default:  rd_d = {31'b0, irq_en_q};
      endcase
    end
  end

  // A flag raised in the same cycle as its clearing read wins.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rd_q        <= '0;
      div_q       <= DEFAULT_BAUD_DIV;
      irq_en_q    <= 1'b0;
      rx_byte_q   <= '0;
      rx_vld_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      if (wr_hit && i_DBusAddr == REG_BAUD) div_q <= clamp_div(baud_wr);
      if (wr_hit && i_DBusAddr == REG_CTRL && i_DBusByteEn[0]) irq_en_q <= i_DBusWd[0];
      if (rx_deliver) begin
        rx_byte_q <= rx_shift_q;
        rx_vld_q  <= 1'b1;
      end else if (data_rd) begin
        rx_vld_q <= 1'b0;
      end
      if (rx_deliver && rx_vld_q && !data_rd) overrun_q <= 1'b1;
      else if (status_rd)                     overrun_q <= 1'b0;
      if (rx_deliver && rx_stop_low) frame_err_q <= 1'b1;
      else if (status_rd)            frame_err_q <= 1'b0;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      rx_meta_q  <= i_UartRx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Each bit lasts div+1 clocks; the counter reloads from div_q at every bit boundary.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    fifo_pop   = 1'b0;
    if (tx_state_q == TX_IDLE || (tx_state_q == TX_STOP && tx_cnt_q == 16'd0)) begin
      tx_state_d = TX_IDLE;
      if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        tx_shift_d = fifo_dat;
        tx_cnt_d   = div_q;
        tx_state_d = TX_START;
      end
    end else if (tx_cnt_q != 16'd0) begin
      tx_cnt_d = tx_cnt_q - 16'd1;
    end else begin
      tx_cnt_d = div_q;
      if (tx_state_q == TX_START) begin
        tx_bit_d   = 3'd0;
        tx_state_d = TX_DATA;
      end else begin
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      end
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_deliver  = 1'b0;
    rx_stop_low = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_cnt_d   = {1'b0, div_q[15:1]};
          rx_state_d = RX_START;
        end
      end
      default: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_cnt_d = div_q;
          if (rx_state_q == RX_START) begin
            rx_bit_d   = 3'd0;
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          end else if (rx_state_q == RX_DATA) begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          end else begin
            rx_deliver  = 1'b1;
            rx_stop_low = ~rx_sync_q;
            rx_state_d  = RX_IDLE;
          end
        end
      end
    endcase
  end

  assign o_UartTx = (tx_state_q == TX_START) ? 1'b0 :
                    (tx_state_q == TX_DATA)  ? tx_shift_q[tx_bit_q] : 1'b1;
  assign o_DBusRd = rd_q;
  assign o_Irq    = rx_vld_q | (fifo_empty & irq_en_q);

endmodule

// File: tb/tb_dbus_uart.sv
// Self-checking bench for dbus_uart: register map, TX waveform, RX holding-register flags.
module tb_dbus_uart;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_BAUD = 2'd2, A_CTRL = 2'd3;

  logic        clk = 1'b0, rst = 1'b1, sel = 1'b0, re = 1'b0, we = 1'b0, rx = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic [3:0]  ben = 4'h0;
  logic [31:0] wd = 32'h0;
  logic [31:0] rd;
  logic        tx, irq;

  int total = 0, bad = 0;
  logic        cap  [0:2047];
  logic        expw [0:2047];
  bit          cap_ok;
  logic [31:0] rv;
  // RX holding-register model
  logic        m_vld = 1'b0, m_ovr = 1'b0, m_fe = 1'b0;
  logic [7:0]  m_byte = 8'h0;

  dbus_uart #(.TX_DEPTH(8), .DEFAULT_BAUD_DIV(16'd867)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Sel(sel), .i_DBusAddr(addr), .i_DBusRe(re), .i_DBusWe(we),
    .i_DBusByteEn(ben), .i_DBusWd(wd), .o_DBusRd(rd), .i_UartRx(rx), .o_UartTx(tx), .o_Irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [31:0] exp_status();
    return {27'b0, m_fe, m_ovr, m_vld, 1'b1, 1'b0};
  endfunction

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk); sel = 1'b1; we = 1'b1; addr = a; wd = d; ben = be;
    @(negedge clk); sel = 1'b0; we = 1'b0; ben = 4'h0;
  endtask

  task automatic rdreg(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); sel = 1'b1; re = 1'b1; addr = a;
    @(negedge clk); sel = 1'b0; re = 1'b0; d = rd;
    if (a == A_STATUS) begin m_ovr = 1'b0; m_fe = 1'b0; end
    if (a == A_DATA) m_vld = 1'b0;
  endtask

  task automatic build_frame(input logic [7:0] b, input int base, input int t);
    for (int i = 0; i < 10 * t; i++) begin
      int k;
      k = i / t;
      expw[base + i] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k - 1];
    end
  endtask

  task automatic capture(input int n);
    int w;
    w = 0;
    cap_ok = 1'b0;
    while (tx !== 1'b0 && w < 400) begin @(negedge clk); w++; end
    if (tx === 1'b0) begin
      cap_ok = 1'b1;
      for (int i = 0; i < n; i++) begin cap[i] = tx; @(negedge clk); end
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int t);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); rx = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k - 1];
      repeat (t - 1) @(negedge clk);
    end
    @(negedge clk); rx = 1'b1;
    repeat (3 * t) @(negedge clk);
    if (m_vld) m_ovr = 1'b1;
    m_vld = 1'b1; m_byte = b;
    if (!stop) m_fe = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_rd got=%h exp=0", rd); end
    rst = 1'b0;
    rdreg(A_STATUS, rv);
    total++; if (rv !== 32'h2) begin bad++; $display("FAIL reset_status got=%h exp=2", rv); end
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL idle_tx got=%b exp=1", tx); end
    rdreg(A_BAUD, rv);
    total++; if (rv !== 32'd867) begin bad++; $display("FAIL reset_baud got=%0d exp=867", rv); end
    @(negedge clk);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rd_idle_zero got=%h exp=0", rd); end
  endtask

  task automatic test_regs();
    logic [15:0] v;
    v = 16'($urandom_range(4, 65535));
    wr(A_BAUD, {16'hFFFF, v}, 4'hF); rdreg(A_BAUD, rv);
    total++; if (rv !== {16'h0, v}) begin bad++; $display("FAIL baud_rw got=%h exp=%h", rv, v); end
    wr(A_BAUD, 32'h0000_AB00, 4'h2); rdreg(A_BAUD, rv);
    total++; if (rv !== {16'h0, 8'hAB, v[7:0]}) begin bad++; $display("FAIL baud_lane1 got=%h exp=%h", rv, {8'hAB, v[7:0]}); end
    wr(A_BAUD, 32'($urandom_range(0, 3)), 4'h3); rdreg(A_BAUD, rv);
    total++; if (rv !== 32'd4) begin bad++; $display("FAIL baud_clamp got=%0d exp=4", rv); end
    wr(A_CTRL, 32'h1, 4'h1); rdreg(A_CTRL, rv);
    total++; if (rv !== 32'h1) begin bad++; $display("FAIL ctrl_rw got=%h exp=1", rv); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_txempty got=%b exp=1", irq); end
    wr(A_CTRL, 32'h0, 4'h1); wr(A_STATUS, 32'hFF, 4'hF);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_off got=%b exp=0", irq); end
    rdreg(A_STATUS, rv);
    total++; if (rv !== 32'h2) begin bad++; $display("FAIL status_wr_ignored got=%h exp=2", rv); end
    wr(A_BAUD, 32'd15, 4'h3);
  endtask

  task automatic test_tx_single();
    logic [7:0] bytes [3];
    int errs, first, lows;
    bytes[0] = 8'hA5; bytes[1] = 8'($urandom); bytes[2] = 8'($urandom);
    for (int f = 0; f < 3; f++) begin
      build_frame(bytes[f], 0, 16);
      fork
        capture(160);
        begin wr(A_DATA, {24'h0, bytes[f]}, 4'h1); @(negedge clk); rdreg(A_STATUS, rv); end
      join
      total++; if (rv !== 32'h2) begin bad++; $display("FAIL tx_empty_after_pop got=%h exp=2", rv); end
      total++;
      if (!cap_ok) begin bad++; $display("FAIL tx_start_timeout byte=%h got=no_start exp=start", bytes[f]); end
      else begin
        errs = 0; first = -1;
        for (int i = 0; i < 160; i++) if (cap[i] !== expw[i]) begin errs++; if (first < 0) first = i; end
        if (errs != 0) begin bad++; $display("FAIL tx_frame byte=%h bad_samples=%0d first=%0d exp=0", bytes[f], errs, first); end
      end
    end
    wr(A_DATA, 32'h55, 4'hE);
    lows = 0;
    repeat (40) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    total++; if (lows != 0) begin bad++; $display("FAIL tx_lane0_off low_cycles=%0d exp=0", lows); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [9];
    int errs, first;
    for (int i = 0; i < 9; i++) begin b[i] = 8'($urandom); build_frame(b[i], i * 160, 16); end
    for (int i = 1440; i < 1540; i++) expw[i] = 1'b1;
    fork
      capture(1540);
      begin
        for (int i = 0; i < 9; i++) begin
          @(negedge clk); sel = 1'b1; we = 1'b1; addr = A_DATA; wd = {24'h0, b[i]}; ben = 4'h1;
        end
        @(negedge clk); sel = 1'b0; we = 1'b0; ben = 4'h0;
        rdreg(A_STATUS, rv);
      end
    join
    total++; if (rv !== 32'h1) begin bad++; $display("FAIL fifo_full_status got=%h exp=1", rv); end
    total++;
    if (!cap_ok) begin bad++; $display("FAIL b2b_start_timeout got=no_start exp=start"); end
    else begin
      errs = 0; first = -1;
      for (int i = 0; i < 1540; i++) if (cap[i] !== expw[i]) begin errs++; if (first < 0) first = i; end
      if (errs != 0) begin bad++; $display("FAIL b2b_frames bad_samples=%0d first=%0d exp=0", errs, first); end
    end
  endtask

  task automatic test_rx();
    logic [7:0] b;
    send_rx(8'h3C, 1'b1, 16);
    total++; if (irq !== m_vld) begin bad++; $display("FAIL rx_irq got=%b exp=%b", irq, m_vld); end
    rdreg(A_STATUS, rv);
    total++; if (rv !== 32'h6) begin bad++; $display("FAIL rx_valid_status got=%h exp=6", rv); end
    rdreg(A_DATA, rv);
    total++; if (rv !== 32'h3C) begin bad++; $display("FAIL rx_data got=%h exp=3c", rv); end
    rdreg(A_STATUS, rv);
    total++; if (rv !== exp_status()) begin bad++; $display("FAIL rx_valid_clear got=%h exp=%h", rv, exp_status()); end
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1, 16);
      rdreg(A_DATA, rv);
      total++; if (rv !== {24'h0, m_byte}) begin bad++; $display("FAIL rx_rand got=%h exp=%h", rv, m_byte); end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] a, b;
    a = 8'($urandom); b = ~a;
    send_rx(a, 1'b1, 16); send_rx(b, 1'b1, 16);
    total++; if (rv === 32'hx || exp_status() !== 32'hE) begin bad++; $display("FAIL ovr_model got=%h exp=e", exp_status()); end
    rdreg(A_STATUS, rv);
    total++; if (rv !== 32'hE) begin bad++; $display("FAIL ovr_status got=%h exp=e", rv); end
    rdreg(A_DATA, rv);
    total++; if (rv !== {24'h0, b}) begin bad++; $display("FAIL ovr_data got=%h exp=%h", rv, b); end
    rdreg(A_STATUS, rv);
    total++; if (rv !== exp_status()) begin bad++; $display("FAIL ovr_cleared got=%h exp=%h", rv, exp_status()); end
  endtask

  task automatic test_frame_err();
    logic [7:0] x;
    x = 8'($urandom);
    send_rx(x, 1'b0, 16);
    repeat (48) @(negedge clk);
    rdreg(A_STATUS, rv);
    total++; if (rv !== 32'h16) begin bad++; $display("FAIL ferr_status got=%h exp=16", rv); end
    rdreg(A_DATA, rv);
    total++; if (rv !== {24'h0, x}) begin bad++; $display("FAIL ferr_data got=%h exp=%h", rv, x); end
    rdreg(A_STATUS, rv);
    total++; if (rv !== exp_status()) begin bad++; $display("FAIL ferr_cleared got=%h exp=%h", rv, exp_status()); end
    wr(A_BAUD, 32'd31, 4'h3);
    @(negedge clk); rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL glitch_irq got=%b exp=0", irq); end
    rdreg(A_STATUS, rv);
    total++; if (rv !== 32'h2) begin bad++; $display("FAIL glitch_status got=%h exp=2", rv); end
  endtask

  task automatic test_reset_midframe();
    int lows;
    wr(A_DATA, 32'h0, 4'h1);
    repeat (50) @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL midframe_tx got=%b exp=0", tx); end
    rst = 1'b1; #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_forces_idle got=%b exp=1", tx); end
    @(negedge clk); rst = 1'b0;
    lows = 0;
    repeat (300) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    total++; if (lows != 0) begin bad++; $display("FAIL frame_discarded low_cycles=%0d exp=0", lows); end
    rdreg(A_STATUS, rv);
    total++; if (rv !== 32'h2) begin bad++; $display("FAIL post_reset_status got=%h exp=2", rv); end
    rdreg(A_BAUD, rv);
    total++; if (rv !== 32'd867) begin bad++; $display("FAIL post_reset_baud got=%0d exp=867", rv); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_tx_single();
    test_back_to_back();
    test_rx();
    test_overrun();
    test_frame_err();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
